// File: rtl/net_state_monitor_if.sv
// Bundle of observed net, clear strobe and debounced status exported by net_state_monitor.
// The master side drives the net and clr; the slave side is the monitor.
interface net_state_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  logic             net;
  logic             clr;
  logic             o;
  logic             valid;
  logic [1:0]       state;
  logic             float_err;
  logic             short_err;
  logic [CNT_W-1:0] float_cnt;
  logic [CNT_W-1:0] short_cnt;

  modport master (
    output net,
    output clr,
    input  o,
    input  valid,
    input  state,
    input  float_err,
    input  short_err,
    input  float_cnt,
    input  short_cnt
  );

  modport slave (
    input  net,
    input  clr,
    output o,
    output valid,
    output state,
    output float_err,
    output short_err,
    output float_cnt,
    output short_cnt
  );
endinterface

// File: rtl/net_state_monitor.sv
// Observes one resolved 4-state net, debounces its class (low/high/float/short) and keeps
// sticky fault flags plus saturating entry counters for the float and short conditions.
module net_state_monitor #(
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  net_state_monitor_if.slave io_mon
);

  localparam int unsigned      RUN_W   = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(SETTLE_CYCLES);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    StFloat = 2'b00,
    StLow   = 2'b01,
    StHigh  = 2'b10,
    StShort = 2'b11
  } state_e;

  state_e           r_state, w_state_d;
  state_e           r_cls, w_cls;
  logic [RUN_W-1:0] r_run, w_run_d;
  logic             r_o, w_o_d;
  logic             r_float_err, w_float_err_d;
  logic             r_short_err, w_short_err_d;
  logic [CNT_W-1:0] r_float_cnt, w_float_cnt_d;
  logic [CNT_W-1:0] r_short_cnt, w_short_cnt_d;
  logic             w_float_entry;
  logic             w_short_entry;

  // Case equality distinguishes z (nothing pulling) from x (pull networks fighting).
  always_comb begin
    if (io_mon.net === 1'b0) begin
      w_cls = StLow;
    end else if (io_mon.net === 1'b1) begin
      w_cls = StHigh;
    end else if (io_mon.net === 1'bz) begin
      w_cls = StFloat;
    end else begin
      w_cls = StShort;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StFloat;
      r_cls       <= StFloat;
      r_run       <= '0;
      r_o         <= 1'b0;
      r_float_err <= 1'b0;
      r_short_err <= 1'b0;
      r_float_cnt <= '0;
      r_short_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_cls       <= w_cls;
      r_run       <= w_run_d;
      r_o         <= w_o_d;
      r_float_err <= w_float_err_d;
      r_short_err <= w_short_err_d;
      r_float_cnt <= w_float_cnt_d;
      r_short_cnt <= w_short_cnt_d;
    end
  end

  always_comb begin
    w_run_d = RUN_ONE;
    if (w_cls == r_cls) begin
      w_run_d = (r_run == RUN_MAX) ? RUN_MAX : r_run + RUN_ONE;
    end
    w_state_d = r_state;
    if ((w_run_d == RUN_MAX) && (w_cls != r_state)) begin
      w_state_d = w_cls;
    end
  end

  always_comb begin
    w_float_entry = (w_state_d == StFloat) && (r_state != StFloat);
    w_short_entry = (w_state_d == StShort) && (r_state != StShort);

    w_o_d = r_o;
    if (w_state_d == StLow) begin
      w_o_d = 1'b0;
    end else if (w_state_d == StHigh) begin
      w_o_d = 1'b1;
    end

    // Clear first, then the entry event; a flag survives clr while its fault is still present.
    w_float_err_d = w_float_entry | (r_float_err & (~io_mon.clr | (r_state == StFloat)));
    w_short_err_d = w_short_entry | (r_short_err & (~io_mon.clr | (r_state == StShort)));

    w_float_cnt_d = io_mon.clr ? '0 : r_float_cnt;
    if (w_float_entry && (w_float_cnt_d != CNT_MAX)) begin
      w_float_cnt_d = w_float_cnt_d + CNT_ONE;
    end
    w_short_cnt_d = io_mon.clr ? '0 : r_short_cnt;
    if (w_short_entry && (w_short_cnt_d != CNT_MAX)) begin
      w_short_cnt_d = w_short_cnt_d + CNT_ONE;
    end

    io_mon.o         = r_o;
    io_mon.valid     = (r_state == StLow) || (r_state == StHigh);
    io_mon.state     = r_state;
    io_mon.float_err = r_float_err;
    io_mon.short_err = r_short_err;
    io_mon.float_cnt = r_float_cnt;
    io_mon.short_cnt = r_short_cnt;
  end

endmodule

// File: tb/tb_net_state_monitor.sv
// Randomised and directed bench for net_state_monitor against a sample-history reference model.
module tb_net_state_monitor;
  localparam int unsigned S  = 3;
  localparam int unsigned CW = 8;
  localparam int          CNT_SAT = (1 << CW) - 1;
  localparam int unsigned VW = 6 + 2 * CW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  net_state_monitor_if #(.CNT_W(CW)) ifc ();

  net_state_monitor #(
    .SETTLE_CYCLES(S),
    .CNT_W        (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_mon(ifc.slave)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Model: class codes follow the state encoding (0 float, 1 low, 2 high, 3 short).
  int m_state;
  bit m_o;
  bit m_ferr, m_serr;
  int m_fcnt, m_scnt;
  int hist[$];

  function automatic int classify(logic v);
    if (v === 1'b0) return 1;
    if (v === 1'b1) return 2;
    if (v === 1'bz) return 0;
    return 3;
  endfunction

  function automatic logic pick(int k);
    logic v;
    case (k)
      0:       v = 1'b0;
      1:       v = 1'b1;
      2:       v = 1'bz;
      default: v = 1'bx;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_o     = 1'b0;
    m_ferr  = 1'b0;
    m_serr  = 1'b0;
    m_fcnt  = 0;
    m_scnt  = 0;
    hist.delete();
  endtask

  // The stable state follows the net once the last S samples since reset all agree.
  task automatic model_edge(int cls, bit clr);
    int  prev;
    bit  stable;
    bit  ent_f, ent_s;
    prev  = m_state;
    ent_f = 1'b0;
    ent_s = 1'b0;
    hist.push_back(cls);
    if (hist.size() > S) void'(hist.pop_front());
    stable = (hist.size() == S);
    foreach (hist[i]) if (hist[i] != cls) stable = 1'b0;
    if (stable && cls != m_state) begin
      m_state = cls;
      ent_f   = (cls == 0);
      ent_s   = (cls == 3);
    end
    if (m_state == 1) m_o = 1'b0;
    else if (m_state == 2) m_o = 1'b1;
    if (clr) begin
      m_fcnt = 0;
      m_scnt = 0;
      m_ferr = m_ferr && (prev == 0);
      m_serr = m_serr && (prev == 3);
    end
    if (ent_f) begin
      m_ferr = 1'b1;
      m_fcnt = (m_fcnt < CNT_SAT) ? m_fcnt + 1 : CNT_SAT;
    end
    if (ent_s) begin
      m_serr = 1'b1;
      m_scnt = (m_scnt < CNT_SAT) ? m_scnt + 1 : CNT_SAT;
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [1:0]    st;
    logic [CW-1:0] fc, sc;
    st = 2'(m_state);
    fc = CW'(m_fcnt);
    sc = CW'(m_scnt);
    return {st, m_o, (m_state == 1 || m_state == 2), m_ferr, m_serr, fc, sc};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {ifc.state, ifc.o, ifc.valid, ifc.float_err, ifc.short_err,
            ifc.float_cnt, ifc.short_cnt};
  endfunction

  // Called just after an edge (or at a negedge); returns #1 after the next rising edge.
  task automatic drive(logic v, logic c);
    ifc.net = v;
    ifc.clr = c;
    @(posedge clk);
    model_edge(classify(ifc.net), c);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    ifc.net = 1'b0;
    ifc.clr = 1'b0;
    model_reset();
    #12;
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset: got %h expected %h", dut_vec(), exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_high_settle();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL high_settle edge %0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 5; i++) begin
      drive((i < 2) ? 1'bx : 1'b1, 1'b0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL glitch edge %0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_short_clr();
    for (int i = 0; i < 5; i++) begin
      drive(1'bx, (i == 3) ? 1'b1 : 1'b0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL short_clr edge %0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_saturate();
    for (int r = 0; r < 300; r++) begin
      for (int i = 0; i < 6; i++) begin
        drive((i < 3) ? 1'bz : 1'b0, 1'b0);
        vectors++;
        if (dut_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL saturate round %0d edge %0d: got %h expected %h",
                   r, i, dut_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_clr_on_entry();
    drive(1'b0, 1'b1);
    for (int r = 0; r < 7; r++) begin
      for (int i = 0; i < 6; i++) drive((i < 3) ? 1'bz : 1'b0, 1'b0);
    end
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL clr_on_entry pre: got %h expected %h", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'bz, (i == 2) ? 1'b1 : 1'b0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL clr_on_entry edge %0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) drive(1'bx, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected %h", dut_vec(), exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL after_reset edge %0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 120; n++) begin
      int k;
      int len;
      k   = int'($urandom_range(0, 3));
      len = int'($urandom_range(1, 5));
      for (int j = 0; j < len; j++) begin
        drive(pick(k), ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
        vectors++;
        if (dut_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL random run %0d edge %0d: got %h expected %h",
                   n, j, dut_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_high_settle();
    test_glitch();
    test_short_clr();
    test_saturate();
    test_clr_on_entry();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/net_state_monitor.md
Name: net_state_monitor

Overview:
- Clocked observer for one resolved 4-state net, i.e. the output of a Junction-style resolver fed by NMOS/PMOS pull networks.
- Samples the net every clock and classifies it as driven-low, driven-high, floating (z) or shorted (x).
- Debounces the classification and exports a clean 2-state value plus validity to synchronous logic.
- Latches sticky fault flags and saturating event counters for float and short conditions.

Parameters:
- SETTLE_CYCLES, 3, consecutive identical samples required before the stable state changes; legal range >= 1.
- CNT_W, 8, width of each saturating event counter.

Ports:
- clk  input  1  clock; all sampling on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- net  input  1  resolved 4-state net under observation (0/1/z/x).
- clr  input  1  synchronous clear of flags and counters.
- o  output  1  debounced logic value of net.
- valid  output  1  high while the stable state is LOW or HIGH.
- state  output  2  stable state: 00 FLOAT, 01 LOW, 10 HIGH, 11 SHORT.
- float_err  output  1  sticky, set on entry to FLOAT.
- short_err  output  1  sticky, set on entry to SHORT.
- float_cnt  output  CNT_W  saturating count of entries into FLOAT.
- short_cnt  output  CNT_W  saturating count of entries into SHORT.

Behaviour:
- Classification of each sample uses case-equality:
  - net===0 -> LOW; net===1 -> HIGH; net===z -> FLOAT; net===x -> SHORT.
- Internal registers: cls_q (class of previous sample) and run (run length, 0..SETTLE_CYCLES).
- On each edge:
  - If the sampled class equals cls_q, run = min(run+1, SETTLE_CYCLES).
  - Otherwise run = 1.
  - cls_q is then updated to the sampled class.
- State transition: when the updated run == SETTLE_CYCLES and the sampled class != state, state takes the sampled class on that same edge.
  - Latency: a net change that is stable before edge 1 appears on state after edge SETTLE_CYCLES.
  - SETTLE_CYCLES=1 gives a one-edge update.
- Glitch rejection: runs shorter than SETTLE_CYCLES never change state.
- o:
  - Equals 0 in LOW and 1 in HIGH.
  - Holds its last driven value in FLOAT and SHORT.
- valid = (state==LOW or state==HIGH), combinational from state.
- Entry events (a state transition into FLOAT or SHORT):
  - Sets the corresponding sticky flag.
  - Increments the corresponding counter; counters saturate at 2^CNT_W-1 with no wrap.
  - Remaining in the same state produces no further events.
- clr:
  - Zeroes both counters and both flags on the edge it is sampled high.
  - If an entry event occurs on the same edge, the clear applies first and the event second: counter = 1, flag = 1.
  - If clr is high while state is SHORT (or FLOAT), the matching flag stays set; a persistent fault cannot be cleared away.
- Reset (rst_n low, any time, including mid-run):
  - state=FLOAT, o=0, valid=0, flags=0, counters=0.
  - cls_q=FLOAT, run=0.
  - Reset entry into FLOAT is not counted and does not set float_err.
- First edge after reset release: run becomes 1 whatever the class, so LOW/HIGH is reached no earlier than edge SETTLE_CYCLES.
- net values other than 0/1/z/x cannot occur in 4-state simulation; no extra handling is required.

Test Plan:
- Reset, then net=1 held for 5 edges (SETTLE_CYCLES=3) -> state=10, o=1, valid=1 from edge 3; flags=0, counters=0.
- From HIGH, net=x for 2 edges then back to 1 -> state stays HIGH, short_err=0, short_cnt=0 (glitch rejected).
- From HIGH, net=x for 3 edges -> state=11, short_err=1, short_cnt=1, valid=0, o holds 1; clr pulsed while still x -> short_cnt=0, short_err stays 1.
- Alternate net z(3 edges)/0(3 edges) 300 times with CNT_W=8 -> float_cnt saturates at 255, float_err=1, state ends LOW with o=0.
- clr asserted on the same edge as a FLOAT entry, with float_cnt=7 beforehand -> float_cnt=1, float_err=1.
- rst_n pulled low asynchronously mid-run while in SHORT with counters nonzero -> immediately state=00, o=0, all flags and counters 0; after release, net=0 -> LOW only after 3 edges.
